// File: rtl/vga_capture_if.sv
// Framebuffer write port used by vga_capture; master drives, slave is the memory side.
interface vga_capture_if #(
  parameter int ADDR_W = 19
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: rebuilds pixel coordinates, checks line/frame timing and grabs one frame.
// Optional 2x2 decimation when VGA_CAPTURE_DECIMATE_EN is defined.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 19
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_in,
  input  logic [7:0] pixel_in,
  input  logic       capture_req,
  output logic       busy,
  output logic       done,
  output logic       locked,
  output logic       err_hline,
  output logic       err_vframe,
  output logic       err_short,
  vga_capture_if.master fb
);

`ifdef VGA_CAPTURE_DECIMATE_EN
  localparam int FRAME_PIX = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
`endif
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [9:0]        H_ACT_L   = 10'(H_ACTIVE);
  localparam logic [15:0]       H_TOT_L   = 16'(H_TOTAL);
  localparam logic [15:0]       V_TOT_L   = 16'(V_TOTAL);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, FINISH} state_t;

  state_t state, state_next;

  logic       hs1, hs2, vs1, vs2, bl1, bl2, req1;
  logic [7:0] px1;
  logic       hs_fall, vs_fall, vs_rise, bl_fall;
  logic [9:0] x, y;
  logic       keep;

  logic        h_armed, v_armed, period_bad;
  logic [15:0] hcnt, lcnt;
  logic [1:0]  good_cnt;
  logic        h_mis, v_mis;

  logic              write_now, last_write, short_end, accept;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r, addr_cnt;
  logic [7:0]        wr_data_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      {hs1, hs2, vs1, vs2, bl1, bl2, req1} <= '0;
      px1 <= '0;
    end else begin
      hs1  <= hsync_in;
      hs2  <= hs1;
      vs1  <= vsync_in;
      vs2  <= vs1;
      bl1  <= blank_in;
      bl2  <= bl1;
      req1 <= capture_req;
      px1  <= pixel_in;
    end
  end

  assign hs_fall = hs2 & ~hs1;
  assign vs_fall = vs2 & ~vs1;
  assign vs_rise = ~vs2 & vs1;
  assign bl_fall = bl2 & ~bl1;

  // x/y describe the pixel currently held in stage 1
  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (bl_fall)                   x <= '0;
      else if (bl1 && x != 10'h3FF)  x <= x + 10'd1;
      if (vs_fall)                     y <= '0;
      else if (bl_fall && y != 10'h3FF) y <= y + 10'd1;
    end
  end

  assign h_mis = hs_fall & h_armed & (hcnt != H_TOT_L);
  assign v_mis = vs_fall & v_armed & (lcnt != V_TOT_L);

  // An hsync edge coinciding with a vsync edge belongs to the new frame period
  always_ff @(posedge clock) begin
    if (reset) begin
      h_armed    <= 1'b0;
      v_armed    <= 1'b0;
      hcnt       <= '0;
      lcnt       <= '0;
      period_bad <= 1'b0;
      good_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      if (hs_fall) begin
        h_armed <= 1'b1;
        hcnt    <= 16'd1;
      end else if (hcnt != 16'hFFFF) begin
        hcnt <= hcnt + 16'd1;
      end
      if (vs_fall) begin
        v_armed <= 1'b1;
        lcnt    <= hs_fall ? 16'd1 : 16'd0;
      end else if (hs_fall && lcnt != 16'hFFFF) begin
        lcnt <= lcnt + 16'd1;
      end
      if (h_mis || v_mis) begin
        locked     <= 1'b0;
        good_cnt   <= '0;
        period_bad <= ~vs_fall;
      end else if (vs_fall) begin
        period_bad <= 1'b0;
        if (period_bad) begin
          good_cnt <= '0;
        end else begin
          if (good_cnt != 2'd2) good_cnt <= good_cnt + 2'd1;
          if (good_cnt != 2'd0) locked <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_hline  <= 1'b0;
      err_vframe <= 1'b0;
      err_short  <= 1'b0;
    end else begin
      if (h_mis)       err_hline <= 1'b1;
      else if (accept) err_hline <= 1'b0;
      if (v_mis)       err_vframe <= 1'b1;
      else if (accept) err_vframe <= 1'b0;
      if (short_end)   err_short <= 1'b1;
      else if (accept) err_short <= 1'b0;
    end
  end

`ifdef VGA_CAPTURE_DECIMATE_EN
  assign keep = ~x[0] & ~y[0];
`else
  assign keep = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req1)                   state_next = WAIT_VS;
      WAIT_VS: if (vs_rise)                state_next = ACTIVE;
      ACTIVE:  if (last_write || vs_fall)  state_next = FINISH;
      FINISH:                              state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == WAIT_VS) || (state == ACTIVE);
    done       = (state == FINISH);
    accept     = (state == IDLE) && req1;
    write_now  = (state == ACTIVE) && bl1 && (x < H_ACT_L) && keep;
    last_write = write_now && (addr_cnt == LAST_ADDR);
    short_end  = (state == ACTIVE) && vs_fall && !last_write;
  end

  // Address advances by one per accepted pixel; no coordinate multiply
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      addr_cnt  <= '0;
    end else begin
      wr_en_r <= write_now;
      if (state == WAIT_VS) begin
        addr_cnt  <= '0;
        wr_addr_r <= '0;
      end else if (write_now) begin
        wr_data_r <= px1;
        wr_addr_r <= addr_cnt;
        addr_cnt  <= addr_cnt + 1'b1;
      end
    end
  end

  assign fb.wr_en   = wr_en_r;
  assign fb.wr_addr = wr_addr_r;
  assign fb.wr_data = wr_data_r;

endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the team's VGA timing/pixel driver.
- Consumes the hsync/vsync/blank/pixel stream the driver produces (25 MHz, 640x480@60, active-low syncs, blank high = active video).
- Reconstructs pixel coordinates, checks line and frame timing, and on request writes exactly one full frame into a framebuffer write port.
- Used for loopback self-test and for frame grab in the image-processing path.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- H_TOTAL, 800, expected clocks between hsync falling edges.
- V_TOTAL, 525, expected lines between vsync falling edges.
- ADDR_W, 19, framebuffer address width; must hold H_ACTIVE*V_ACTIVE-1.

Ports:
- clock  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-high.
- hsync_in  in  1  active-low horizontal sync.
- vsync_in  in  1  active-low vertical sync.
- blank_in  in  1  1 = active video pixel.
- pixel_in  in  8  grey pixel value.
- capture_req  in  1  single-cycle request to grab the next complete frame.
- busy  out  1  capture in progress.
- done  out  1  one-cycle pulse when the capture ends.
- wr_en  out  1  framebuffer write strobe.
- wr_addr  out  ADDR_W  framebuffer address.
- wr_data  out  8  pixel to write.
- locked  out  1  timing matches parameters.
- err_hline  out  1  sticky: line period mismatch.
- err_vframe  out  1  sticky: frame line-count mismatch.
- err_short  out  1  sticky: frame ended before H_ACTIVE*V_ACTIVE pixels.

Behaviour:
- One clock domain: clock. Reset is synchronous and active-high on port reset. All outputs are 0 after reset.
- Input stage:
  - All five inputs are registered once (stage 1).
  - Edge detect compares stage 1 against stage 2.
  - A pixel at the input in cycle k appears on wr_data/wr_en in cycle k+2.
- Coordinates:
  - x counts stage-1 blank-high cycles and clears on a blank falling edge.
  - y increments on each blank falling edge and clears on a vsync falling edge.
  - Both saturate at 1023.
- Line timing:
  - hcnt counts clocks between hsync falling edges.
  - On each falling edge, hcnt != H_TOTAL sets err_hline.
- Frame timing:
  - lcnt counts hsync falling edges between vsync falling edges.
  - On each vsync falling edge, lcnt != V_TOTAL sets err_vframe.
  - The first edge after reset only arms the checks; it is not a comparison.
- locked:
  - Sets after 2 consecutive vsync periods with no line or frame mismatch.
  - Clears in the same cycle the mismatch is detected.
- FSM states:
  - IDLE: capture_req -> WAIT_VS. Clears err_* and asserts busy.
  - WAIT_VS: on a vsync rising edge (end of pulse) -> ACTIVE. wr_addr = 0.
  - ACTIVE: for every stage-1 pixel with blank=1 and x < H_ACTIVE, issue wr_en=1 and wr_data=pixel; wr_addr then increments.
  - ACTIVE -> FINISH after the write at address H_ACTIVE*V_ACTIVE-1.
  - ACTIVE -> FINISH with err_short set on a vsync falling edge that arrives before that write.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Address generation is incremental; no multiplier. Pixels with x >= H_ACTIVE are never written.
- capture_req outside IDLE is ignored.
- capture_req coinciding with a vsync rising edge: the coincident edge is not used; capture starts at the following frame.
- Reset mid-capture: the next edge forces IDLE, with wr_en=0, busy=0, done=0.
- The err_* flags stay sticky until reset or the next accepted capture_req. Timing checks run in all states.

Optional Feature:
- Macro: VGA_CAPTURE_DECIMATE_EN.
- When defined:
  - 2x2 decimation: write only pixels with x[0]=0 and y[0]=0.
  - Frame size becomes (H_ACTIVE/2)*(V_ACTIVE/2); the terminal address is 76799 for defaults.
  - err_short applies to this smaller count.
- When undefined: full-resolution capture as above.

Test Plan:
- Drive ideal 640x480 timing with pixel = x[7:0] -> locked=1 after 2nd vsync falling edge; err_* stay 0.
- capture_req mid-frame -> no write until vsync rising edge; first write wr_addr=0, wr_data=0; write at addr 639 has data 0x7F; done pulses after addr 307199; exactly 307200 wr_en cycles.
- Stretch one line to 801 clocks -> err_hline=1 and locked=0 within that cycle+2; locked re-asserts after 2 clean frames.
- Emit vsync after 300 active lines during capture -> err_short=1, done pulses, last wr_addr=191999.
- Assert reset while wr_addr=1000 -> next cycle busy=0, wr_en=0; a new capture_req restarts at addr 0.
- With VGA_CAPTURE_DECIMATE_EN -> 76800 writes; addr 1 carries x=2,y=0; addr 320 carries x=0,y=2.
